op1_loader: RTL and testbench
=============================

OP1_LOADER -- requirements
Module: op1_loader

Interface
- REQ-001 SHALL have port clock_in, input, 1 bit: single clock; all state changes on its rising edge.
- REQ-002 SHALL have port reset_n_in, input, 1 bit: reset, asynchronous, active-low.
- REQ-003 SHALL have port lane_data_in, input, 4 bits: unsigned activation for the current lane.
- REQ-004 SHALL have port lane_inv_in, input, 1 bit: weight sign for the current lane; 1 means negative.
- REQ-005 SHALL have port lane_valid_in, input, 1 bit: lane word offered.
- REQ-006 SHALL have port lane_ready_out, output, 1 bit: loader accepts the lane word.
- REQ-007 SHALL have port clear_in, input, 1 bit: synchronous abort of the partial fill.
- REQ-008 SHALL have port data_out, output, 128 bits: lane k occupies bits [4k+3:4k]; drives data0_in..data31_in of op1.
- REQ-009 SHALL have port inv_out, output, 32 bits: bit k drives invk_in of op1.
- REQ-010 SHALL have port inv_count_out, output, 6 bits: number of set bits in inv_out, 0..32; the downstream correction for ~x = -x-1.
- REQ-011 SHALL have port frame_valid_out, output, 1 bit: data_out, inv_out and inv_count_out hold a complete frame.
- REQ-012 SHALL have port frame_ready_in, input, 1 bit: consumer takes the frame.

Function
- REQ-013 SHALL accept a lane word in a cycle when lane_valid_in=1 and lane_ready_out=1 (a lane handshake).
- REQ-014 SHALL write accepted lanes in order 0..31 using a 5-bit lane counter.
- REQ-015 SHALL use states FILL and PRESENT (single-buffer build).
- REQ-016 SHALL in FILL drive lane_ready_out=1 and increment the counter per lane handshake.
- REQ-017 SHALL on the lane handshake at count 31 wrap the counter to 0, enter PRESENT, and assert frame_valid_out on the next cycle.
- REQ-018 SHALL compute inv_count_out incrementally during fill, with no combinational popcount on the outputs, and register it with the frame.
- REQ-019 SHALL in PRESENT drive lane_ready_out=0 and hold data_out, inv_out and inv_count_out stable until a frame handshake (frame_valid_out=1 and frame_ready_in=1).
- REQ-020 SHALL on a frame handshake deassert frame_valid_out on the next cycle and return to FILL.
- REQ-021 SHALL add no latency at the frame boundary beyond one cycle from the 32nd lane handshake to frame_valid_out=1.
- REQ-022 SHALL when clear_in=1 reset the counter and partial inv count to 0.
- REQ-023 SHALL when clear_in=1 discard the lane handshake in that same cycle.
- REQ-024 SHALL leave a presented frame and frame_valid_out unaffected by clear_in.
- REQ-025 SHALL in FILL keep the data_out/inv_out lanes not yet written at their previous frame's values.
- REQ-026 SHALL drive frame_valid_out=0 while it is in FILL.

Reset
- REQ-027 SHALL on reset_n_in=0 immediately set state FILL and lane counter=0.
- REQ-028 SHALL on reset_n_in=0 immediately set data_out=0, inv_out=0 and inv_count_out=0.
- REQ-029 SHALL on reset_n_in=0 immediately set frame_valid_out=0 and lane_ready_out=0.
- REQ-030 SHALL raise lane_ready_out no earlier than the first rising edge after reset_n_in deasserts.
- REQ-031 SHALL drop any partial fill or pending frame when reset is asserted mid-operation.

Configuration
- REQ-032 SHALL, with OP1_LOADER_DBUF_EN defined, implement two frame buffers (fill and present).
- REQ-033 SHALL, with OP1_LOADER_DBUF_EN defined, keep lane_ready_out=1 during PRESENT while the fill buffer is not complete.
- REQ-034 SHALL, with OP1_LOADER_DBUF_EN defined, swap buffers on a frame handshake when the fill buffer holds 32 lanes, keeping frame_valid_out=1 continuously.
- REQ-035 SHALL, with OP1_LOADER_DBUF_EN defined, on a completed fill while a frame is held, stall lane_ready_out=0 until the frame handshake, then swap.
- REQ-036 SHALL, with OP1_LOADER_DBUF_EN undefined, behave exactly as REQ-015 to REQ-026.

Verification
- REQ-037 SHALL cover: 32 lanes with data=k[3:0], inv=k[0] -> frame_valid_out one cycle after lane 31; data_out lane k = k mod 16; inv_out=0xAAAAAAAA; inv_count_out=16.
- REQ-038 SHALL cover: all 32 lanes data=4'hF, inv=1 -> inv_count_out=32; data_out all ones.
- REQ-039 SHALL cover: frame_ready_in=0 for 10 cycles after frame_valid_out -> outputs stable; lane_ready_out=0 (single buffer).
- REQ-040 SHALL cover: clear_in after 17 lanes, then 32 new lanes -> frame contains only the new lanes; counter wraps to 0.
- REQ-041 SHALL cover: reset_n_in pulsed low after 9 lanes -> all outputs 0 asynchronously; the next full frame is correct.
- REQ-042 SHALL cover, with OP1_LOADER_DBUF_EN defined: continuous lane_valid_in=1 and frame_ready_in=1 -> one frame handshake every 32 cycles; lane_ready_out never drops after the first frame.

Source files
------------

// File: rtl/op1_loader.sv
`default_nettype none
// ============================================================================
// Module   : op1_loader
// Purpose  : Serial-to-parallel operand loader for op1. Collects 32 lane
//            words (4-bit activation + weight-sign bit) in order 0..31 and
//            presents them as one 128-bit data frame, a 32-bit sign vector
//            and a running count of set sign bits for the ~x = -x-1 fix-up.
// Revision : 1.0 - initial release
//
// Ports
//   clock_in        in   1    clock, rising edge
//   reset_n_in      in   1    asynchronous active-low reset
//   lane_data_in    in   4    activation for the current lane
//   lane_inv_in     in   1    weight sign for the current lane (1 = negative)
//   lane_valid_in   in   1    lane word offered
//   lane_ready_out  out  1    loader accepts the lane word
//   clear_in        in   1    synchronous abort of the partial fill
//   data_out        out  128  lane k at bits [4k+3:4k]
//   inv_out         out  32   bit k = sign of lane k
//   inv_count_out   out  6    number of set bits in inv_out (0..32)
//   frame_valid_out out  1    a complete frame is presented
//   frame_ready_in  in   1    consumer takes the frame
//
// Configuration
//   OP1_LOADER_DBUF_EN  defined   : separate fill and present buffers, so
//                                   the next frame can be filled while the
//                                   current one is held.
//                       undefined : single buffer, filling only while no
//                                   frame is presented.
// ============================================================================
module op1_loader (
  input  logic         clock_in,
  input  logic         reset_n_in,
  input  logic [3:0]   lane_data_in,
  input  logic         lane_inv_in,
  input  logic         lane_valid_in,
  output logic         lane_ready_out,
  input  logic         clear_in,
  output logic [127:0] data_out,
  output logic [31:0]  inv_out,
  output logic [5:0]   inv_count_out,
  output logic         frame_valid_out,
  input  logic         frame_ready_in
);

  localparam logic [0:0] S_FILL    = 1'b0;
  localparam logic [0:0] S_PRESENT = 1'b1;
  localparam logic [4:0] C_LAST_LANE = 5'd31;

  logic [0:0]   r_state;
  logic [0:0]   w_state_nxt;
  logic         r_ready_en;     // holds lane_ready_out low until the first edge out of reset
  logic [4:0]   r_count;
  logic [5:0]   r_inv_acc;      // sign bits accepted so far in the current fill
  logic [127:0] r_fill_data;
  logic [31:0]  r_fill_inv;
  logic [127:0] w_fill_data_nxt;
  logic [31:0]  w_fill_inv_nxt;
  logic [5:0]   w_frame_cnt;
  logic         w_lane_hs;
  logic         w_last;
  logic         w_frame_hs;

  // clear_in wins over a simultaneous lane handshake: the word is dropped.
  assign w_lane_hs   = lane_valid_in & lane_ready_out & ~clear_in;
  assign w_last      = w_lane_hs & (r_count == C_LAST_LANE);
  assign w_frame_hs  = frame_valid_out & frame_ready_in;
  // Count including the lane being accepted now; only meaningful on w_last.
  assign w_frame_cnt = r_inv_acc + {5'd0, lane_inv_in};

  // Fill buffer with the current lane merged in, so a frame completing this
  // cycle can be handed to the present side without an extra cycle.
  always_comb begin
    w_fill_data_nxt = r_fill_data;
    w_fill_inv_nxt  = r_fill_inv;
    if (w_lane_hs) begin
      w_fill_data_nxt[{r_count, 2'b00} +: 4] = lane_data_in;
      w_fill_inv_nxt[r_count]                = lane_inv_in;
    end
  end

  // Lane counter, partial sign count and fill buffer.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_ready_en  <= 1'b0;
      r_count     <= 5'd0;
      r_inv_acc   <= 6'd0;
      r_fill_data <= '0;
      r_fill_inv  <= '0;
    end else begin
      r_ready_en  <= 1'b1;
      r_fill_data <= w_fill_data_nxt;
      r_fill_inv  <= w_fill_inv_nxt;
      if (clear_in) begin
        r_count   <= 5'd0;
        r_inv_acc <= 6'd0;
      end else if (w_lane_hs) begin
        r_count   <= r_count + 5'd1;   // wraps 31 -> 0 at frame end
        r_inv_acc <= w_last ? 6'd0 : w_frame_cnt;
      end
    end
  end

  // State register.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

`ifdef OP1_LOADER_DBUF_EN
  logic [127:0] r_pres_data;
  logic [31:0]  r_pres_inv;
  logic [5:0]   r_pres_cnt;
  logic [5:0]   r_pend_cnt;     // sign count of a completed fill waiting for a swap
  logic         r_fill_full;
  logic         w_load;
  logic [5:0]   w_load_cnt;

  // Move the fill buffer to the present side when it completes and the
  // present side is free (empty, or being taken this cycle), or when a
  // previously completed fill finally sees the frame handshake.
  assign w_load     = (w_last & ((r_state == S_FILL) | w_frame_hs)) |
                      (r_fill_full & w_frame_hs);
  assign w_load_cnt = w_last ? w_frame_cnt : r_pend_cnt;

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_pres_data <= '0;
      r_pres_inv  <= '0;
      r_pres_cnt  <= 6'd0;
      r_pend_cnt  <= 6'd0;
      r_fill_full <= 1'b0;
    end else begin
      r_fill_full <= (r_fill_full | w_last) & ~w_load;
      if (w_last) begin
        r_pend_cnt <= w_frame_cnt;
      end
      if (w_load) begin
        r_pres_data <= w_fill_data_nxt;
        r_pres_inv  <= w_fill_inv_nxt;
        r_pres_cnt  <= w_load_cnt;
      end
    end
  end

  // Next state: stay in PRESENT across a swap so frame_valid_out stays high.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FILL:    if (w_last)                 w_state_nxt = S_PRESENT;
      S_PRESENT: if (w_frame_hs && !w_load)  w_state_nxt = S_FILL;
      default:                               w_state_nxt = S_FILL;
    endcase
  end

  // Outputs.
  always_comb begin
    frame_valid_out = (r_state == S_PRESENT);
    lane_ready_out  = r_ready_en & ~r_fill_full;
  end

  assign data_out      = r_pres_data;
  assign inv_out       = r_pres_inv;
  assign inv_count_out = r_pres_cnt;
`else
  logic [5:0] r_frame_cnt;

  // Single buffer: the fill buffer is the presented frame, so lanes not yet
  // rewritten keep the previous frame's values.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_frame_cnt <= 6'd0;
    end else if (w_last) begin
      r_frame_cnt <= w_frame_cnt;
    end
  end

  // Next state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FILL:    if (w_last)     w_state_nxt = S_PRESENT;
      S_PRESENT: if (w_frame_hs) w_state_nxt = S_FILL;
      default:                   w_state_nxt = S_FILL;
    endcase
  end

  // Outputs.
  always_comb begin
    frame_valid_out = (r_state == S_PRESENT);
    lane_ready_out  = r_ready_en & (r_state == S_FILL);
  end

  assign data_out      = r_fill_data;
  assign inv_out       = r_fill_inv;
  assign inv_count_out = r_frame_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_op1_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_op1_loader
// Purpose  : Self-checking bench for op1_loader. Lane words are pushed
//            through a handshake task while a lane-array model tracks which
//            value each lane should hold; presented frames, sign counts,
//            reset and clear behaviour are compared against that model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_op1_loader;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [3:0]   lane_data;
  logic         lane_inv;
  logic         lane_valid;
  logic         lane_ready;
  logic         clear;
  logic [127:0] data_out;
  logic [31:0]  inv_out;
  logic [5:0]   inv_count;
  logic         frame_valid;
  logic         frame_ready;

  always #5 clk = ~clk;

  op1_loader dut (
    .clock_in        (clk),
    .reset_n_in      (reset_n),
    .lane_data_in    (lane_data),
    .lane_inv_in     (lane_inv),
    .lane_valid_in   (lane_valid),
    .lane_ready_out  (lane_ready),
    .clear_in        (clear),
    .data_out        (data_out),
    .inv_out         (inv_out),
    .inv_count_out   (inv_count),
    .frame_valid_out (frame_valid),
    .frame_ready_in  (frame_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: value each lane should hold, and the next lane to be written.
  logic [3:0] mdl_data [32];
  logic       mdl_inv  [32];
  int         mcount;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 32; k++) begin
      mdl_data[k] = 4'd0;
      mdl_inv[k]  = 1'b0;
    end
    mcount = 0;
  endtask

  function automatic logic [127:0] exp_data();
    logic [127:0] r = '0;
    for (int k = 0; k < 32; k++) r[k*4 +: 4] = mdl_data[k];
    return r;
  endfunction

  function automatic logic [31:0] exp_inv();
    logic [31:0] r = '0;
    for (int k = 0; k < 32; k++) r[k] = mdl_inv[k];
    return r;
  endfunction

  function automatic logic [5:0] exp_cnt();
    int s = 0;
    for (int k = 0; k < 32; k++) s += int'(mdl_inv[k]);
    return 6'(s);
  endfunction

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic push_lane(input logic [3:0] d, input logic iv, input int gap);
    int n = 0;
    lane_valid = 1'b0;
    repeat (gap) @(negedge clk);
    lane_data  = d;
    lane_inv   = iv;
    lane_valid = 1'b1;
    while (!lane_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("lane_ready_wait", lane_ready, 1);
    @(negedge clk);
    lane_valid = 1'b0;
    mdl_data[mcount] = d;
    mdl_inv[mcount]  = iv;
    mcount = (mcount + 1) % 32;
  endtask

  task automatic push_random(input int lanes, input int max_gap);
    for (int k = 0; k < lanes; k++)
      push_lane(4'($urandom), 1'($urandom), int'($urandom_range(max_gap, 0)));
  endtask

  task automatic check_frame(input string tag);
    check({tag, "_valid"}, frame_valid, 1);
    check({tag, "_data"},  data_out,    exp_data());
    check({tag, "_inv"},   inv_out,     exp_inv());
    check({tag, "_cnt"},   inv_count,   exp_cnt());
  endtask

  task automatic take_frame(input string tag);
    int n = 0;
    frame_ready = 1'b1;
    while (!frame_valid && n < 64) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    frame_ready = 1'b0;
    check({tag, "_valid_drop"}, frame_valid, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"},  data_out,    0);
    check({tag, "_inv"},   inv_out,     0);
    check({tag, "_cnt"},   inv_count,   0);
    check({tag, "_valid"}, frame_valid, 0);
    check({tag, "_ready"}, lane_ready,  0);
  endtask

  initial begin
    reset_n     = 1'b0;
    lane_data   = 4'd0;
    lane_inv    = 1'b0;
    lane_valid  = 1'b0;
    clear       = 1'b0;
    frame_ready = 1'b0;
    model_reset();

    // Reset state and ready release.
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;
    #1 check("ready_before_edge", lane_ready, 0);
    @(negedge clk);
    check("ready_after_edge", lane_ready, 1);

    // Ramp frame: data = k mod 16, inv = k[0].
    for (int k = 0; k < 32; k++) begin
      push_lane(4'(k), 1'(k & 1), 0);
      if (k == 30) check("ramp_not_yet_valid", frame_valid, 0);
    end
    check_frame("ramp");
    check("ramp_data_const", data_out, 128'hFEDCBA9876543210FEDCBA9876543210);
    check("ramp_inv_const",  inv_out,  32'hAAAAAAAA);
    check("ramp_cnt_const",  inv_count, 6'd16);

    // Back-pressure for 10 cycles, with clear pulsed during the hold.
    for (int c = 0; c < 10; c++) begin
      clear = (c < 3);
      @(negedge clk);
      check_frame("hold");
`ifndef OP1_LOADER_DBUF_EN
      check("hold_ready", lane_ready, 0);
`endif
    end
    clear = 1'b0;
    take_frame("ramp_take");

    // All-ones frame: full sign count.
    for (int k = 0; k < 32; k++) push_lane(4'hF, 1'b1, 0);
    check_frame("ones");
    check("ones_cnt_const",  inv_count, 6'd32);
    check("ones_data_const", data_out,  {128{1'b1}});
    take_frame("ones_take");

    // Partial fill of 17 lanes, then clear with a simultaneous lane offer.
    push_random(17, 1);
`ifndef OP1_LOADER_DBUF_EN
    check("partial_data_keep", data_out, exp_data());
    check("partial_inv_keep",  inv_out,  exp_inv());
`endif
    check("partial_not_valid", frame_valid, 0);
    lane_data  = 4'($urandom);
    lane_inv   = 1'b1;
    lane_valid = 1'b1;
    clear      = 1'b1;
    @(negedge clk);
    clear      = 1'b0;
    lane_valid = 1'b0;
    mcount     = 0;
    push_random(32, 0);
    check_frame("after_clear");
    take_frame("after_clear_take");

    // Counter must have wrapped to 0: one more lane lands in lane 0.
    push_lane(4'($urandom), 1'($urandom), 0);
`ifndef OP1_LOADER_DBUF_EN
    check("wrap_lane0", data_out, exp_data());
`endif

    // Mid-fill asynchronous reset.
    push_random(8, 0);
    #2 reset_n = 1'b0;
    #1 check_all_zero("async_reset");
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    push_random(32, 2);
    check_frame("post_reset");
    take_frame("post_reset_take");

    // Random frames with gaps and random consumer delay.
    for (int f = 0; f < 3; f++) begin
      push_random(32, 2);
      repeat ($urandom_range(3, 0)) @(negedge clk);
      check_frame("rand");
      take_frame("rand_take");
    end

`ifdef OP1_LOADER_DBUF_EN
    // Streaming: one frame handshake every 32 cycles, ready never drops.
    begin : stream
      int last_hs;
      int seen;
      last_hs     = -1;
      seen        = 0;
      lane_valid  = 1'b1;
      frame_ready = 1'b1;
      for (int c = 0; c < 200; c++) begin
        lane_data = 4'($urandom);
        lane_inv  = 1'($urandom);
        @(negedge clk);
        if (seen > 0) check("stream_ready", lane_ready, 1);
        if (frame_valid) begin
          if (last_hs >= 0) check("stream_spacing", 128'(c - last_hs), 128'd32);
          last_hs = c;
          seen++;
        end
      end
      check("stream_frames_seen", 128'(seen >= 5), 128'd1);
      lane_valid  = 1'b0;
      frame_ready = 1'b0;
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Overall time bound.
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
